// File: rtl/sdram_arb_pkg.sv
// Shared constants for the SDRAM frame arbiter: state encoding, parameter defaults, sizing helper.
package sdram_arb_pkg;

  // Parameter defaults used by the arbiter and its address generators
  localparam int unsigned ADDR_W_DEF       = 20;
  localparam int unsigned BURST_LEN_DEF    = 8;
  localparam int unsigned FRAME_BURSTS_DEF = 30;
  localparam int unsigned REFRESH_CYC_DEF  = 780;

  // Arbiter state encoding
  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REFRESH = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_READ    = 2'd3;

  // Bits needed to hold 0..n-1, never less than one bit
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_frame_addr_gen.sv
// Burst index / ping-pong buffer tracker for one side (write or read) of the frame buffer.
// addr reflects the buffer about to be latched when latch_buf is asserted at frame start,
// so the arbiter can register the correct address in the same cycle it grants the burst.
module sdram_frame_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned BURST_LEN      = BURST_LEN_DEF,
  parameter int unsigned FRAME_BURSTS   = FRAME_BURSTS_DEF,
  parameter bit          TOGGLE_ON_WRAP = 1'b1
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              advance,
  input  logic              latch_buf,
  input  logic              buf_in,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_done
);

  localparam int unsigned      IDX_W    = width_of(FRAME_BURSTS);
  localparam int unsigned      OFF_W    = ADDR_W - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BURSTS - 1);
  localparam logic [OFF_W-1:0] STEP     = OFF_W'(BURST_LEN);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sel_q, sel_d;
  logic             done_q, done_d;
  logic             take_in;

  // A new buffer is only taken at the start of a frame
  assign take_in = latch_buf && (idx_q == '0);

  // Next index, buffer select and wrap pulse
  always_comb begin
    idx_d  = idx_q;
    sel_d  = sel_q;
    done_d = 1'b0;
    if (take_in) begin
      sel_d = buf_in;
    end
    if (advance) begin
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        done_d = 1'b1;
        if (TOGGLE_ON_WRAP) begin
          sel_d = ~sel_q;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q  <= '0;
      sel_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      done_q <= done_d;
    end
  end

  assign addr       = {(take_in ? buf_in : sel_q), OFF_W'(idx_q) * STEP};
  assign frame_done = done_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates refresh, VGA frame reads and camera frame writes onto the SDRAM burst engine.
// One command at a time; each command is held until its matching ack pulse.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
  parameter int unsigned FRAME_BURSTS = FRAME_BURSTS_DEF,
  parameter int unsigned REFRESH_CYC  = REFRESH_CYC_DEF
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              write_ack,
  input  logic              read_ack,
  input  logic              refresh_ack,
  output logic              write_en,
  output logic              read_en,
  output logic              refresh_en,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic              busy
);

  localparam int unsigned      TMR_W      = width_of(REFRESH_CYC);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYC - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic              write_en_q, write_en_d;
  logic              read_en_q, read_en_d;
  logic              refresh_en_q, refresh_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              last_rd_q, last_rd_d;
  logic              frame_valid_q, frame_valid_d;
  logic              ref_pend_q, ref_pend_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              wr_adv, rd_adv, rd_grant;
  logic              take_wr, take_rd;
  logic              rd_ok;
  logic              wr_done, rd_done;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // A frame completing this very edge already makes reads eligible
  assign rd_ok = rd_req && (frame_valid_q || wr_done);

  // Refresh interval timer and pending flag; a new expiry wins over a same-cycle ack
  always_comb begin
    tmr_d      = tmr_q;
    ref_pend_d = ref_pend_q;
    if (!init_done) begin
      tmr_d = TMR_RELOAD;
    end else if (tmr_q == '0) begin
      tmr_d = TMR_RELOAD;
    end else begin
      tmr_d = tmr_q - TMR_W'(1);
    end
    if ((state_q == ST_REFRESH) && refresh_ack) begin
      ref_pend_d = 1'b0;
    end
    if (init_done && (tmr_q == '0)) begin
      ref_pend_d = 1'b1;
    end
  end

  // Grant / completion state machine with registered command outputs
  always_comb begin
    state_d       = state_q;
    write_en_d    = write_en_q;
    read_en_d     = read_en_q;
    refresh_en_d  = refresh_en_q;
    addr_d        = addr_q;
    last_rd_d     = last_rd_q;
    frame_valid_d = frame_valid_q | wr_done;
    wr_adv        = 1'b0;
    rd_adv        = 1'b0;
    rd_grant      = 1'b0;
    take_wr       = 1'b0;
    take_rd       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (init_done) begin
          if (ref_pend_q) begin
            state_d      = ST_REFRESH;
            refresh_en_d = 1'b1;
          end else if (rd_ok && !(last_rd_q && wr_req)) begin
            take_rd = 1'b1;
          end else if (wr_req) begin
            take_wr = 1'b1;
          end else if (rd_ok) begin
            take_rd = 1'b1;
          end
        end
        if (take_rd) begin
          state_d   = ST_READ;
          read_en_d = 1'b1;
          rd_grant  = 1'b1;
          addr_d    = rd_addr;
          last_rd_d = 1'b1;
        end
        if (take_wr) begin
          state_d    = ST_WRITE;
          write_en_d = 1'b1;
          addr_d     = wr_addr;
          last_rd_d  = 1'b0;
        end
      end
      ST_REFRESH: begin
        if (refresh_ack) begin
          state_d      = ST_IDLE;
          refresh_en_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (write_ack) begin
          state_d    = ST_IDLE;
          write_en_d = 1'b0;
          wr_adv     = 1'b1;
        end
      end
      ST_READ: begin
        if (read_ack) begin
          state_d   = ST_IDLE;
          read_en_d = 1'b0;
          rd_adv    = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        write_en_d   = 1'b0;
        read_en_d    = 1'b0;
        refresh_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      write_en_q    <= 1'b0;
      read_en_q     <= 1'b0;
      refresh_en_q  <= 1'b0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      last_rd_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      ref_pend_q    <= 1'b0;
      tmr_q         <= TMR_RELOAD;
    end else begin
      state_q       <= state_d;
      write_en_q    <= write_en_d;
      read_en_q     <= read_en_d;
      refresh_en_q  <= refresh_en_d;
      addr_q        <= addr_d;
      busy_q        <= busy_d;
      last_rd_q     <= last_rd_d;
      frame_valid_q <= frame_valid_d;
      ref_pend_q    <= ref_pend_d;
      tmr_q         <= tmr_d;
    end
  end

  // Write side: steps through the buffer, flips to the other buffer at frame end
  sdram_frame_addr_gen #(
    .ADDR_W        (ADDR_W),
    .BURST_LEN     (BURST_LEN),
    .FRAME_BURSTS  (FRAME_BURSTS),
    .TOGGLE_ON_WRAP(1'b1)
  ) u_wr_gen (
    .S_CLK     (S_CLK),
    .RST_N     (RST_N),
    .advance   (wr_adv),
    .latch_buf (1'b0),
    .buf_in    (1'b0),
    .addr      (wr_addr),
    .frame_done(wr_done)
  );

  // Read side: at frame start locks onto the buffer the writer last completed
  sdram_frame_addr_gen #(
    .ADDR_W        (ADDR_W),
    .BURST_LEN     (BURST_LEN),
    .FRAME_BURSTS  (FRAME_BURSTS),
    .TOGGLE_ON_WRAP(1'b0)
  ) u_rd_gen (
    .S_CLK     (S_CLK),
    .RST_N     (RST_N),
    .advance   (rd_adv),
    .latch_buf (rd_grant),
    .buf_in    (~wr_addr[ADDR_W-1]),
    .addr      (rd_addr),
    .frame_done(rd_done)
  );

  assign write_en      = write_en_q;
  assign read_en       = read_en_q;
  assign refresh_en    = refresh_en_q;
  assign addr          = addr_q;
  assign busy          = busy_q;
  assign wr_frame_done = wr_done;
  assign rd_frame_done = rd_done;

endmodule
